fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 enable  in  1  high permits new FIFO reads; low stops issuing reads, buffered data still drains.
REQ-005 fifo_oready  in  1  FIFO read side has data (not empty).
REQ-006 fifo_odata  in  DATA_WIDTH  FIFO read data, valid the cycle after the fifo_rden pulse.
REQ-007 fifo_err  in  1  FIFO error flag (overflow/underflow).
REQ-008 fifo_rden  out  1  FIFO read strobe; one word popped per high cycle.
REQ-009 m_valid  out  1  output stream word available.
REQ-010 m_data  out  DATA_WIDTH  output stream word.
REQ-011 m_ready  in  1  downstream accepts word when m_valid and m_ready are both high.
REQ-012 count  out  16  number of completed output handshakes since reset.
REQ-013 err  out  1  sticky error flag.

Function
REQ-014 FIFO read latency is fixed at 1: word popped by fifo_rden high in cycle N is sampled from fifo_odata on the rising edge closing cycle N+1.
REQ-015 Internal state: 2-entry ordered buffer (head, tail), occupancy occ in {EMPTY, ONE, TWO}, register inflight = fifo_rden of previous cycle.
REQ-016 pop = m_valid and m_ready (same cycle).
REQ-017 fifo_rden = enable and fifo_oready and not reset and (occ + inflight - pop) < 2; combinational from registered state plus those inputs.
REQ-018 On edge with inflight=1, fifo_odata is written into first free buffer slot after accounting for pop in that cycle.
REQ-019 Occupancy transitions: occ_next = occ + inflight - pop; capture and pop in same cycle with occ=ONE: head takes captured word, occ stays ONE; with occ=TWO: tail moves to head, captured word to tail, occ stays TWO.
REQ-020 m_valid = (occ != EMPTY); m_data = head; word order on stream equals FIFO pop order, no loss, no duplication.
REQ-021 m_data and m_valid are stable while m_valid high and m_ready low.
REQ-022 Buffer never overflows: occ + inflight never exceeds 2 by construction.
REQ-023 Throughput: with fifo_oready, enable, m_ready held high, one word per cycle sustained; first m_valid two cycles after first fifo_rden.
REQ-024 Latency: word popped in cycle N appears on m_data no earlier than cycle N+2.
REQ-025 enable deasserted: fifo_rden low the same cycle; an inflight word is still captured; buffered words drain normally.
REQ-026 count increments by 1 on each pop, wraps 0xFFFF -> 0x0000.
REQ-027 err set on any cycle with fifo_err high, or fifo_rden high while fifo_oready low; remains set until reset.
REQ-028 fifo_oready dropping mid-stream: no fifo_rden issued; already inflight word captured normally.

Reset
REQ-029 While reset high: fifo_rden=0, m_valid=0, occ=EMPTY, inflight=0, count=0, err=0; m_data=0.
REQ-030 Reset asserted mid-operation discards buffered and inflight words; fifo_odata in the cycle following reset is ignored.
REQ-031 First fifo_rden possible in first cycle after reset deasserts.

Verification
REQ-032 Reset, FIFO preloaded 0x01..0x04, enable=1, m_ready=1 -> fifo_rden high 4 consecutive cycles, m_data 0x01..0x04 on consecutive cycles starting 2 cycles after first rden, count=4.
REQ-033 m_ready=0, FIFO holds 5 words -> exactly 2 fifo_rden pulses, occ=TWO, m_data=first word stable; then m_ready=1 -> remaining 3 words read, all 5 delivered in order.
REQ-034 Random m_ready (50%) and fifo_oready toggling, 1000 words -> output sequence identical to input, no overflow, err=0, count=1000 mod 65536.
REQ-035 enable dropped while inflight=1 -> fifo_rden low same cycle, inflight word still delivered, no further reads until enable=1.
REQ-036 fifo_err pulsed 1 cycle -> err=1 next cycle, stays 1 until reset; reset asserted with occ=TWO -> m_valid=0, count=0, err=0 next cycle.
REQ-037 count preset scenario: 65537 handshakes -> count=0x0001.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a latency-1 FIFO read port into a valid/ready stream
// through a 2-entry ordered buffer, with a handshake counter and sticky error flag.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_oready,
    input  logic [DATA_WIDTH-1:0] fifo_odata,
    input  logic                  fifo_err,
    output logic                  fifo_rden,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           count,
    output logic                  err
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
    occ_t                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [15:0]           count_q, count_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic [1:0]            after_pop, lvl;
    always_comb begin
        pop        = (occ_q != EMPTY) && m_ready;
        after_pop  = occ_q - {1'b0, pop};
        lvl        = after_pop + {1'b0, inflight_q};
        fifo_rden  = enable && fifo_oready && !reset && (lvl < 2'd2);
        // the returning word lands in the first slot left free after this cycle's pop
        head_d     = (inflight_q && after_pop == 2'd0) ? fifo_odata : pop ? tail_q : head_q;
        tail_d     = (inflight_q && after_pop != 2'd0) ? fifo_odata : tail_q;
        occ_d      = occ_t'(lvl);
        inflight_d = fifo_rden;
        count_d    = count_q + {15'd0, pop};
        err_d      = err_q || fifo_err || (fifo_rden && !fifo_oready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end
    assign m_valid = (occ_q != EMPTY);
    assign m_data  = head_q;
    assign count   = count_q;
    assign err     = err_q;
endmodule
